rec_ma_mc: RTL and testbench
============================

Name: rec_ma_mc

Overview:
Parametrised, multi-channel recursive moving-average filter. It is the successor to the single-channel fixed-width MA block.
- Time-interleaved channels share one datapath. Each channel keeps its own delay line, running sum, write pointer and fill counter.
- Signed data. Division by window size is an arithmetic shift.
- Valid/ready input, registered valid output, and a hardware clear sweep so the delay memory needs no reset.
- Sits between the sample demux and downstream decimation/threshold logic.

Parameters:
DATA_W, 16, signed sample width in bits (>=4)
LOG2_WIN, 3, log2 of window length; WINDOW = 2**LOG2_WIN (1..8)
CHANNELS, 4, number of interleaved channels (1..16)
CH_W, 2, channel index width, >= clog2(CHANNELS), min 1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
clear  in  1  synchronous pulse: restart clear sweep
in_valid  in  1  input sample valid
in_ready  out  1  block accepts sample this cycle
in_ch  in  CH_W  channel of input sample
in_data  in  DATA_W  signed input sample
out_valid  out  1  output sample valid (1-cycle pulse per accepted sample)
out_ch  out  CH_W  channel of output sample
out_data  out  DATA_W  signed windowed average
out_primed  out  1  channel has received >= WINDOW samples since last clear
err_ch  out  1  1-cycle pulse: accepted handshake with in_ch >= CHANNELS

Behaviour:
- Clock clk; reset rst_n is synchronous, active-low.
- State machine has two states, CLEAR and RUN.
- Reset values: state=CLEAR, sweep index=0, in_ready=0, out_valid=0, out_ch=0, out_data=0, out_primed=0, err_ch=0. All per-channel sums, pointers and counters = 0.
- CLEAR state:
  - Zeroes one delay entry per cycle, at index 0..CHANNELS*WINDOW-1.
  - in_ready=0.
  - Goes to RUN the cycle after the last index, so in_ready rises exactly CHANNELS*WINDOW cycles after reset release.
- clear asserted in either state:
  - Sums, pointers and counters zero on that edge.
  - Sweep index = 0 and state = CLEAR.
  - A sample offered in the same cycle is not accepted.
- RUN state: in_ready=1. A sample is accepted when in_valid && in_ready.
- Accepted sample with valid channel c:
  - old = delay[c][ptr[c]]
  - sum_new = sum[c] - old + in_data
  - delay[c][ptr[c]] <= in_data
  - ptr[c] <= ptr[c]+1, wrapping modulo WINDOW
  - sum[c] <= sum_new
  - cnt[c] saturates at WINDOW
- Latency is 1 cycle. On the next cycle:
  - out_valid=1, out_ch=c
  - out_data = sum_new >>> LOG2_WIN (arithmetic, floor), truncated to DATA_W; cannot overflow by construction
  - out_primed = (cnt_new == WINDOW)
- Back-to-back samples on the same channel in consecutive cycles must use the updated sum and pointer, with no hazard.
- Accumulator width is DATA_W+LOG2_WIN, signed. No saturation is needed; the window sum always fits.
- Accepted sample with in_ch >= CHANNELS:
  - No state change, out_valid=0.
  - err_ch=1 for one cycle, one cycle after acceptance.
- out_data and out_ch hold their last values while out_valid=0.
- Reset mid-operation behaves exactly like power-on reset, including the full sweep.

Optional Feature:
Macro REC_MA_ROUND_EN.
- Defined: out_data = (sum_new + 2**(LOG2_WIN-1)) >>> LOG2_WIN, i.e. round half toward +inf. The addition uses width DATA_W+LOG2_WIN+1, so there is no overflow. When LOG2_WIN=0 the rounding term is 0.
- Undefined: plain arithmetic shift (floor).
- Latency and all other behaviour are identical in both builds.

Test Plan:
1. Release reset (defaults: DATA_W=16, LOG2_WIN=3, CHANNELS=4) -> in_ready=0 for exactly 32 cycles, then 1; no out_valid during sweep.
2. Ch0 constant 800, 10 samples -> out_data 100,200,...,800,800,800. out_primed=0 for samples 1-7 and 1 from sample 8. Each output appears 1 cycle after its handshake.
3. Interleave ch0=+800 and ch1=-800 back-to-back every cycle -> ch0 ramps 100..800, ch1 ramps -100..-800; channels independent, out_ch matches.
4. Ch2 impulse 8 followed by zeros -> eight outputs of 1, then 0 forever. Impulse 4 -> outputs 0 without the macro, 1 with REC_MA_ROUND_EN. Impulse -4 -> -1 without, 0 with.
5. Pulse clear after 5 samples on ch0 -> in_ready=0 for 32 cycles. Next sample 800 -> out_data=100, out_primed=0.
6. in_ch=5 accepted while CHANNELS=4 -> err_ch pulses 1 cycle, no out_valid, and subsequent ch0-3 outputs are unchanged.

Source files
------------

// File: rtl/rec_ma_mc.sv
// rec_ma_mc: multi-channel recursive moving-average filter.
//
// Several time-interleaved channels share one datapath. Each channel owns a
// WINDOW-deep delay line, a running sum, a write pointer and a fill counter.
// For every accepted sample the running sum is updated as
//   sum_new = sum - oldest + in_data
// and the output is sum_new divided by WINDOW (arithmetic right shift).
// The delay memory has no reset; instead a clear sweep writes zero into one
// entry per cycle after reset or after a clear pulse, and the block refuses
// input until the sweep has finished.
//
// Optional build macro: REC_MA_ROUND_EN
//   undefined : out_data = floor(sum_new / WINDOW)
//   defined   : out_data = floor((sum_new + WINDOW/2) / WINDOW)  (round half up)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (starts a full clear sweep)
//   clear      synchronous pulse, restarts the clear sweep
//   in_valid   input sample valid
//   in_ready   high in RUN; a sample is accepted when in_valid && in_ready
//   in_ch      channel of the input sample
//   in_data    signed input sample
//   out_valid  one-cycle pulse, one cycle after each accepted valid-channel sample
//   out_ch     channel of the output sample (holds while out_valid is low)
//   out_data   signed windowed average (holds while out_valid is low)
//   out_primed channel has seen at least WINDOW samples since the last clear
//   err_ch     one-cycle pulse, one cycle after accepting a sample with in_ch >= CHANNELS
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready
// and clear is low. in_valid may be asserted at any time; in_ready does not
// depend on in_valid. There is no output back-pressure.

module rec_ma_mc #(
  parameter int DATA_W   = 16,
  parameter int LOG2_WIN = 3,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              out_primed,
  output logic              err_ch
);

  localparam int WINDOW = 1 << LOG2_WIN;
  localparam int DEPTH  = CHANNELS * WINDOW;
  localparam int ACC_W  = DATA_W + LOG2_WIN;
  localparam int PTR_W  = (LOG2_WIN > 0) ? LOG2_WIN : 1;
  localparam int CNT_W  = LOG2_WIN + 1;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CIDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WINDOW);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sweep_idx;

  // Delay memory: channel c occupies entries c*WINDOW .. c*WINDOW+WINDOW-1.
  logic [DATA_W-1:0]       delay_mem [DEPTH];
  logic signed [ACC_W-1:0] sum_q     [CHANNELS];
  logic [PTR_W-1:0]        ptr_q     [CHANNELS];
  logic [CNT_W-1:0]        cnt_q     [CHANNELS];

  logic                    accept;
  logic                    ch_ok;
  logic                    acc_ok;
  logic                    acc_bad;
  logic [CIDX_W-1:0]       ch_idx;
  logic [PTR_W-1:0]        ptr_cur;
  logic [PTR_W-1:0]        ptr_next;
  logic [CNT_W-1:0]        cnt_cur;
  logic [CNT_W-1:0]        cnt_new;
  logic [ADDR_W-1:0]       rw_addr;
  logic [DATA_W-1:0]       old_val;
  logic signed [ACC_W-1:0] sum_new;
  logic [DATA_W-1:0]       avg;

  // Out-of-range channels are steered to index 0 only so that the array
  // reads below stay in bounds; nothing is written for them.
  assign ch_ok   = ({1'b0, in_ch} < CH_LIMIT);
  assign ch_idx  = ch_ok ? in_ch[CIDX_W-1:0] : '0;
  assign accept  = in_valid && in_ready && !clear;
  assign acc_ok  = accept && ch_ok;
  assign acc_bad = accept && !ch_ok;

  assign ptr_cur  = ptr_q[ch_idx];
  assign ptr_next = (ptr_cur == PTR_LAST) ? '0 : ptr_cur + 1'b1;
  assign cnt_cur  = cnt_q[ch_idx];
  assign cnt_new  = (cnt_cur == CNT_FULL) ? cnt_cur : cnt_cur + 1'b1;

  assign rw_addr = ADDR_W'(ch_idx) * ADDR_W'(WINDOW) + ADDR_W'(ptr_cur);
  assign old_val = delay_mem[rw_addr];

  // Sum, pointer and counter are updated on the accepting edge, so a
  // same-channel sample on the very next cycle already sees the new values.
  assign sum_new = sum_q[ch_idx] - ACC_W'($signed(old_val)) + ACC_W'($signed(in_data));

`ifdef REC_MA_ROUND_EN
  // (WINDOW >> 1) is 2**(LOG2_WIN-1), and 0 when LOG2_WIN = 0.
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(WINDOW >> 1);
  logic signed [ACC_W:0] sum_rnd;
  assign sum_rnd = {sum_new[ACC_W-1], sum_new} + RND;
  assign avg     = sum_rnd[DATA_W+LOG2_WIN-1:LOG2_WIN];
`else
  // Arithmetic shift then truncation to DATA_W is exactly this slice.
  assign avg = sum_new[DATA_W+LOG2_WIN-1:LOG2_WIN];
`endif

  // Delay memory: written by the clear sweep or by an accepted sample.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR) begin
        delay_mem[sweep_idx] <= '0;
      end else if (acc_ok) begin
        delay_mem[rw_addr] <= in_data;
      end
    end
  end

  // Control FSM, per-channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      sweep_idx  <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      out_primed <= 1'b0;
      err_ch     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sum_q[i] <= '0;
        ptr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      out_valid <= acc_ok;
      err_ch    <= acc_bad;

      if (acc_ok) begin
        sum_q[ch_idx] <= sum_new;
        ptr_q[ch_idx] <= ptr_next;
        cnt_q[ch_idx] <= cnt_new;
        out_ch        <= in_ch;
        out_data      <= avg;
        out_primed    <= (cnt_new == CNT_FULL);
      end

      if (clear) begin
        state     <= S_CLEAR;
        sweep_idx <= '0;
        in_ready  <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          sum_q[i] <= '0;
          ptr_q[i] <= '0;
          cnt_q[i] <= '0;
        end
      end else begin
        case (state)
          S_CLEAR: begin
            sweep_idx <= sweep_idx + 1'b1;
            if (sweep_idx == LAST_IDX) begin
              sweep_idx <= '0;
              state     <= S_RUN;
              in_ready  <= 1'b1;
            end
          end
          S_RUN: begin
            in_ready <= 1'b1;
          end
          default: begin
            state    <= S_CLEAR;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rec_ma_mc.sv
// Self-checking bench for rec_ma_mc: table-driven vectors with constant
// expectations, hand-written clear/reset/error sequences, and randomized
// traffic checked against a window-of-samples reference model.
module tb_rec_ma_mc;

  localparam int DW    = 16;
  localparam int LW    = 3;
  localparam int NCH   = 4;
  localparam int CHW   = 3;
  localparam int WIN   = 8;
  localparam int SWEEP = NCH * WIN;

`ifdef REC_MA_ROUND_EN
  localparam int EXP_P4 = 1;
  localparam int EXP_M4 = 0;
`else
  localparam int EXP_P4 = 0;
  localparam int EXP_M4 = -1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic           in_valid;
  logic           in_ready;
  logic [CHW-1:0] in_ch;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;
  logic           out_primed;
  logic           err_ch;

  always #5 clk = ~clk;

  rec_ma_mc #(
    .DATA_W  (DW),
    .LOG2_WIN(LW),
    .CHANNELS(NCH),
    .CH_W    (CHW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_primed(out_primed),
    .err_ch    (err_ch)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW+CHW:0] exp_q[$];   // {primed, ch, data}
  int hist[NCH][$];            // last WIN samples per channel
  int n_seen[NCH];
  int got_data;
  int got_primed;
  int last_data = 0;

  typedef struct {
    int ch;
    int data;
    int exp_data;
    int exp_primed;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floor_div(input int s);
    int q;
    q = s / WIN;
    if (s < 0 && q * WIN != s) q = q - 1;
    return q;
  endfunction

  function automatic int model_avg(input int s);
`ifdef REC_MA_ROUND_EN
    return floor_div(s + WIN / 2);
`else
    return floor_div(s);
`endif
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      hist[c].delete();
      n_seen[c] = 0;
    end
  endtask

  task automatic model_push(input int ch, input int data, output int avg, output bit primed);
    int s;
    hist[ch].push_back(data);
    if (hist[ch].size() > WIN) void'(hist[ch].pop_front());
    n_seen[ch]++;
    s = 0;
    for (int k = 0; k < hist[ch].size(); k++) s += hist[ch][k];
    avg    = model_avg(s);
    primed = (n_seen[ch] >= WIN);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one sample, then checks the response one
  // edge later.
  task automatic send(input int ch, input int data);
    int              avg;
    bit              pr;
    logic [DW+CHW:0] e;
    logic [CHW-1:0]  c3;
    logic [DW-1:0]   d16;
    c3  = ch[CHW-1:0];
    d16 = data[DW-1:0];
    check("ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    in_ch    = c3;
    in_data  = d16;
    if (ch < NCH) begin
      model_push(ch, data, avg, pr);
      exp_q.push_back({pr, c3, avg[DW-1:0]});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ch < NCH) begin
      e = exp_q.pop_front();
      check("out_valid", int'(out_valid), 1);
      check("err_ch_quiet", int'(err_ch), 0);
      check("out_ch", int'(out_ch), int'(e[DW+CHW-1:DW]));
      check("out_data", int'($signed(out_data)), int'($signed(e[DW-1:0])));
      check("out_primed", int'(out_primed), int'(e[DW+CHW]));
      got_data   = int'($signed(out_data));
      got_primed = int'(out_primed);
      last_data  = got_data;
    end else begin
      check("bad_ch_no_valid", int'(out_valid), 0);
      check("err_ch_pulse", int'(err_ch), 1);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_no_valid", int'(out_valid), 0);
    check("idle_no_err", int'(err_ch), 0);
    check("idle_hold_data", int'($signed(out_data)), last_data);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      check("sweep_no_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      n++;
    end
    check(name, n, SWEEP);
  endtask

  // Pulses clear with a sample offered in the same cycle (must be dropped).
  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_ch    = '0;
    in_data  = 16'd800;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_no_accept", int'(out_valid), 0);
    model_clear();
    wait_ready("clear_sweep_len");
  endtask

  task automatic add(input int ch, input int data, input int ed, input int ep);
    vec_t v;
    v.ch = ch; v.data = data; v.exp_data = ed; v.exp_primed = ep;
    vecs.push_back(v);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].ch, vecs[i].data);
      check({name, "_data"}, got_data, vecs[i].exp_data);
      check({name, "_primed"}, got_primed, vecs[i].exp_primed);
    end
    vecs.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_primed", int'(out_primed), 0);
    check("rst_err_ch", int'(err_ch), 0);
    rst_n = 1'b1;
    wait_ready("reset_sweep_len");

    // Ch0 constant 800, back-to-back, 10 samples.
    for (int i = 0; i < 10; i++) add(0, 800, (i < 8) ? 100 * (i + 1) : 800, (i >= 7) ? 1 : 0);
    run_table("const_ch0");
    idle();

    // Interleaved ch0 = +800 / ch1 = -800 after a clear.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      add(0, 800, 100 * (i + 1), (i >= 7) ? 1 : 0);
      add(1, -800, -100 * (i + 1), (i >= 7) ? 1 : 0);
    end
    run_table("interleave");

    // Ch2 impulses: 8, then 4, then -4, each followed by zeros.
    add(2, 8, 1, 0);
    for (int k = 1; k < 8; k++) add(2, 0, 1, (k >= 7) ? 1 : 0);
    add(2, 0, 0, 1);
    add(2, 0, 0, 1);
    add(2, 4, EXP_P4, 1);
    for (int k = 1; k < 8; k++) add(2, 0, EXP_P4, 1);
    add(2, 0, 0, 1);
    add(2, -4, EXP_M4, 1);
    for (int k = 1; k < 8; k++) add(2, 0, EXP_M4, 1);
    add(2, 0, 0, 1);
    run_table("impulse");
    idle();

    // Clear after 5 samples on ch0.
    do_clear();
    for (int k = 0; k < 5; k++) begin
      send(0, 800);
      check("pre_clear_ramp", got_data, 100 * (k + 1));
    end
    do_clear();
    send(0, 800);
    check("post_clear_data", got_data, 100);
    check("post_clear_primed", got_primed, 0);

    // Invalid channel: err pulse only, no state change.
    send(5, 1234);
    idle();
    send(7, -5000);
    send(0, 800);
    check("after_err_ch0", got_data, 200);
    send(1, -800);
    check("after_err_ch1", got_data, -100);
    idle();

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      logic signed [DW-1:0] r;
      int ch;
      r = DW'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        ch = ($urandom_range(0, 9) == 0) ? $urandom_range(NCH, 7) : $urandom_range(0, NCH - 1);
        send(ch, int'(r));
      end
    end

    // Reset in the middle of operation: full sweep again, state cleared.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    last_data = 0;
    model_clear();
    wait_ready("midrst_sweep_len");
    send(3, -1000);
    check("midrst_first_data", got_data, -125);
    check("midrst_first_primed", got_primed, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
